branch_resolver: RTL and testbench
==================================

Name: branch_resolver

Overview:
- IF/ID-stage branch decoder. It is the control source that drives the program counter's branch inputs: UncondBr, brTaken, condAddr19, brAddr26 and curAddress.
- Holds the IF/ID pipeline register (fetched instruction plus its PC) and decodes B, CBZ, CBNZ and B.cond.
- Evaluates the branch condition against Rt data and a registered NZCV flag set, and squashes the wrong-path instruction after a taken branch.

Parameters:
- DATA_W, 64, width of the register-file data used for the CBZ/CBNZ zero test.
- NOP_INSTR, 32'hD503201F, instruction word loaded into IF/ID as a bubble.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- instr_in  input  32  instruction read from imem at the current PC address.
- pc_in  input  32  PC address that instr_in was fetched from.
- stall  input  1  hazard-unit hold; IF/ID keeps its contents.
- flag_we  input  1  flag-setting instruction (ADDS/SUBS) writes flags this cycle.
- flags_in  input  4  {N,Z,C,V} from the ALU.
- rt_data  input  DATA_W  register-file read of the Rt index.
- rt_index  output  5  instr_id[4:0], the Rt field, sent to the register-file read port.
- instr_id  output  32  IF/ID instruction.
- valid_id  output  1  IF/ID holds a real (non-bubble) instruction.
- curAddress  output  32  PC of the instruction in IF/ID.
- condAddr19  output  19  instr_id[23:5].
- brAddr26  output  26  instr_id[25:0].
- UncondBr  output  1  IF/ID holds B; selects brAddr26 in the PC.
- brTaken  output  1  redirect the PC this cycle.

Behaviour:
- Reset, on a clk edge with rst=1 (overrides all other inputs, including mid-stall or mid-flush):
  - instr_id=NOP_INSTR, valid_id=0, curAddress=0, flags=4'b0000.
  - As a result UncondBr=0, brTaken=0, condAddr19=0, brAddr26=0 and rt_index=5'h1F.
- IF/ID update, at each edge with rst=0:
  - stall=1: hold instr_id, curAddress and valid_id.
  - else, if brTaken=1 this cycle: load the bubble (NOP_INSTR, valid_id=0, curAddress=pc_in).
  - else: load instr_in and pc_in, with valid_id=1.
- Decode (combinational from IF/ID, only when valid_id=1):
  - B: instr_id[31:26]=6'b000101.
  - CBZ: instr_id[31:24]=8'hB4.
  - CBNZ: instr_id[31:24]=8'hB5.
  - B.cond: instr_id[31:24]=8'h54 with instr_id[4]=0; condition code is instr_id[3:0].
- Branch outputs:
  - UncondBr = valid_id & isB.
  - brTaken = valid_id & ~stall & (isB | isCBZ&(rt_data==0) | isCBNZ&(rt_data!=0) | isBcond&cond_met).
  - stall forces brTaken low, so the held PC is not redirected twice.
- Taken-branch latency: brTaken is asserted in the same cycle the branch sits in IF/ID, and the PC redirects at the next edge. This costs exactly one bubble.
- condAddr19 and brAddr26 are raw fields, driven regardless of decode. Sign extension and the <<2 are done in the PC.
- Flags register: loads flags_in on any edge where flag_we=1 and rst=0. It is independent of stall.
- cond_met truth table:
  - EQ: Z. NE: !Z.
  - HS: C. LO: !C.
  - MI: N. PL: !N.
  - VS: V. VC: !V.
  - HI: C&!Z. LS: !(C&!Z).
  - GE: N==V. LT: N!=V.
  - GT: !Z&(N==V). LE: !(!Z&(N==V)).
  - AL and NV (1110/1111): 1.
- Boundaries:
  - A bubble in IF/ID never branches.
  - A branch held during stall asserts brTaken only in the first cycle with stall=0.
  - A branch immediately after a taken branch is squashed, since it is the wrong path.

Optional Feature:
- Macro: BRANCH_FLAG_BYPASS_EN.
- Defined: B.cond evaluates flags_in whenever flag_we=1 in the same cycle; otherwise it uses the flags register. This allows back-to-back SUBS / B.cond.
- Undefined: B.cond uses only the flags register. Flags written in cycle N are visible to B.cond from cycle N+1.

Decomposition:
- Shared package holds:
  - opcode constants OP_B, OP_CBZ, OP_CBNZ, OP_BCOND;
  - condition-code constants COND_EQ through COND_NV;
  - NOP_INSTR;
  - flag bit positions (N=3, Z=2, C=1, V=0).
- One sub-module, cond_eval: combinational, with inputs cond[3:0] and flags[3:0] and output cond_met.

Test Plan:
- Reset: hold rst=1 for 2 edges with instr_in=B encoding -> valid_id=0, instr_id=32'hD503201F, brTaken=0, curAddress=0.
- Unconditional branch: instr_in=32'h14000002, pc_in=32'h10, stall=0 -> next cycle UncondBr=1, brTaken=1, brAddr26=26'h2, curAddress=32'h10; the following cycle valid_id=0 (bubble).
- CBZ: instr_in=32'hB4000023 (imm19=1, Rt=3).
  - rt_data=0 -> brTaken=1, UncondBr=0, condAddr19=19'h1, rt_index=3.
  - Repeat with rt_data=64'h5 -> brTaken=0 and the next instruction loads with valid_id=1.
- B.cond: pulse flag_we=1 with flags_in=4'b0100 (Z=1), then instr_in=32'h54000040 (B.EQ, imm19=2) -> brTaken=1.
  - With flags=4'b0000 -> brTaken=0.
  - With instr B.GE=32'h5400004A and flags N=1,V=1 -> brTaken=1.
- Stall: branch in IF/ID with stall=1 for 3 cycles -> brTaken=0 and IF/ID unchanged; the first stall=0 cycle gives brTaken=1, and the next cycle is a bubble.
- Bypass (BRANCH_FLAG_BYPASS_EN): same-cycle flag_we=1, flags_in Z=1, with B.EQ in IF/ID -> brTaken=1 when defined, 0 when undefined.

Source files
------------

// File: rtl/branch_resolver_pkg.sv
// Shared constants, condition codes and the branch decode helper for branch_resolver.
// Optional same-cycle flag bypass is selected by BRANCH_FLAG_BYPASS_EN in branch_resolver.sv.
package branch_resolver_pkg;

  localparam logic [5:0]  OP_B      = 6'b000101;
  localparam logic [7:0]  OP_CBZ    = 8'hB4;
  localparam logic [7:0]  OP_CBNZ   = 8'hB5;
  localparam logic [7:0]  OP_BCOND  = 8'h54;

  localparam logic [31:0] NOP_INSTR = 32'hD503201F;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  typedef enum logic [3:0] {
    COND_EQ = 4'h0,
    COND_NE = 4'h1,
    COND_HS = 4'h2,
    COND_LO = 4'h3,
    COND_MI = 4'h4,
    COND_PL = 4'h5,
    COND_VS = 4'h6,
    COND_VC = 4'h7,
    COND_HI = 4'h8,
    COND_LS = 4'h9,
    COND_GE = 4'hA,
    COND_LT = 4'hB,
    COND_GT = 4'hC,
    COND_LE = 4'hD,
    COND_AL = 4'hE,
    COND_NV = 4'hF
  } cond_e;

  typedef struct packed {
    logic is_b;
    logic is_cbz;
    logic is_cbnz;
    logic is_bcond;
  } br_decode_t;

  // B.cond requires bit 4 clear; with it set the word is not a conditional branch.
  function automatic br_decode_t decode_branch(input logic [31:0] instr);
    br_decode_t d;
    d.is_b     = (instr[31:26] == OP_B);
    d.is_cbz   = (instr[31:24] == OP_CBZ);
    d.is_cbnz  = (instr[31:24] == OP_CBNZ);
    d.is_bcond = (instr[31:24] == OP_BCOND) && !instr[4];
    return d;
  endfunction

endpackage

// File: rtl/cond_eval.sv
// Combinational evaluation of an AArch64 condition code against an {N,Z,C,V} flag set.
module cond_eval
  import branch_resolver_pkg::*;
(
  input  logic [3:0] cond,
  input  logic [3:0] flags,
  output logic       cond_met
);

  logic w_n, w_z, w_c, w_v;

  assign w_n = flags[FLAG_N];
  assign w_z = flags[FLAG_Z];
  assign w_c = flags[FLAG_C];
  assign w_v = flags[FLAG_V];

  always_comb begin
    cond_met = 1'b1;
    case (cond)
      COND_EQ: cond_met = w_z;
      COND_NE: cond_met = !w_z;
      COND_HS: cond_met = w_c;
      COND_LO: cond_met = !w_c;
      COND_MI: cond_met = w_n;
      COND_PL: cond_met = !w_n;
      COND_VS: cond_met = w_v;
      COND_VC: cond_met = !w_v;
      COND_HI: cond_met = w_c && !w_z;
      COND_LS: cond_met = !(w_c && !w_z);
      COND_GE: cond_met = (w_n == w_v);
      COND_LT: cond_met = (w_n != w_v);
      COND_GT: cond_met = !w_z && (w_n == w_v);
      COND_LE: cond_met = !(!w_z && (w_n == w_v));
      default: cond_met = 1'b1;
    endcase
  end

endmodule

// File: rtl/branch_resolver.sv
// IF/ID register plus B/CBZ/CBNZ/B.cond resolution driving the PC's branch inputs.
// Define BRANCH_FLAG_BYPASS_EN to let B.cond see flags_in in the same cycle flag_we is high.
module branch_resolver #(
  parameter int          DATA_W    = 64,
  parameter logic [31:0] NOP_INSTR = branch_resolver_pkg::NOP_INSTR
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [31:0]       instr_in,
  input  logic [31:0]       pc_in,
  input  logic              stall,
  input  logic              flag_we,
  input  logic [3:0]        flags_in,
  input  logic [DATA_W-1:0] rt_data,
  output logic [4:0]        rt_index,
  output logic [31:0]       instr_id,
  output logic              valid_id,
  output logic [31:0]       curAddress,
  output logic [18:0]       condAddr19,
  output logic [25:0]       brAddr26,
  output logic              UncondBr,
  output logic              brTaken
);

  import branch_resolver_pkg::*;

  logic [31:0] r_instr;
  logic [31:0] r_pc;
  logic        r_valid;
  logic [3:0]  r_flags;

  br_decode_t  w_dec;
  logic [3:0]  w_cond_flags;
  logic        w_cond_met;
  logic        w_rt_zero;
  logic        w_br_taken;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_instr <= NOP_INSTR;
      r_pc    <= '0;
      r_valid <= 1'b0;
      r_flags <= 4'b0000;
    end else begin
      if (flag_we) begin
        r_flags <= flags_in;
      end
      if (!stall) begin
        if (w_br_taken) begin
          // Wrong-path fetch is replaced by a bubble; its PC is kept for visibility.
          r_instr <= NOP_INSTR;
          r_pc    <= pc_in;
          r_valid <= 1'b0;
        end else begin
          r_instr <= instr_in;
          r_pc    <= pc_in;
          r_valid <= 1'b1;
        end
      end
    end
  end

`ifdef BRANCH_FLAG_BYPASS_EN
  assign w_cond_flags = flag_we ? flags_in : r_flags;
`else
  assign w_cond_flags = r_flags;
`endif

  cond_eval u_cond_eval (
    .cond     (r_instr[3:0]),
    .flags    (w_cond_flags),
    .cond_met (w_cond_met)
  );

  always_comb begin
    w_dec = decode_branch(r_instr);
    if (!r_valid) begin
      w_dec = '0;
    end
  end

  assign w_rt_zero = (rt_data == '0);

  // Stall gates the redirect so a held branch only fires once, when it is released.
  assign w_br_taken = r_valid && !stall &&
                      (w_dec.is_b ||
                       (w_dec.is_cbz && w_rt_zero) ||
                       (w_dec.is_cbnz && !w_rt_zero) ||
                       (w_dec.is_bcond && w_cond_met));

  assign instr_id   = r_instr;
  assign valid_id   = r_valid;
  assign curAddress = r_pc;
  assign rt_index   = r_instr[4:0];
  // Target fields read as zero while IF/ID holds a bubble.
  assign condAddr19 = r_valid ? r_instr[23:5] : '0;
  assign brAddr26   = r_valid ? r_instr[25:0] : '0;
  assign UncondBr   = w_dec.is_b;
  assign brTaken    = w_br_taken;

endmodule

// File: tb/tb_branch_resolver.sv
// Self-checking bench for branch_resolver: directed scenarios plus randomized traffic vs. a reference model.
module tb_branch_resolver;

  localparam int          DATA_W = 64;
  localparam logic [31:0] NOP    = 32'hD503201F;
  localparam logic [31:0] ADD_I  = 32'h8B020020;

  logic              clk = 1'b0;
  logic              rst;
  logic [31:0]       instr_in;
  logic [31:0]       pc_in;
  logic              stall;
  logic              flag_we;
  logic [3:0]        flags_in;
  logic [DATA_W-1:0] rt_data;
  logic [4:0]        rt_index;
  logic [31:0]       instr_id;
  logic              valid_id;
  logic [31:0]       curAddress;
  logic [18:0]       condAddr19;
  logic [25:0]       brAddr26;
  logic              UncondBr;
  logic              brTaken;

  int checks = 0;
  int errors = 0;

  // Reference state: what IF/ID and the flag register should hold.
  logic [31:0] m_instr;
  logic [31:0] m_pc;
  logic        m_valid;
  logic [3:0]  m_flags;

  always #5 clk = ~clk;

  branch_resolver #(.DATA_W(DATA_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .instr_in   (instr_in),
    .pc_in      (pc_in),
    .stall      (stall),
    .flag_we    (flag_we),
    .flags_in   (flags_in),
    .rt_data    (rt_data),
    .rt_index   (rt_index),
    .instr_id   (instr_id),
    .valid_id   (valid_id),
    .curAddress (curAddress),
    .condAddr19 (condAddr19),
    .brAddr26   (brAddr26),
    .UncondBr   (UncondBr),
    .brTaken    (brTaken)
  );

  // ARM rule: cond[3:1] picks a base test, cond[0] inverts it (except 1111).
  function automatic bit ref_cond(input logic [3:0] c, input logic [3:0] f);
    bit n, z, cy, v, r;
    n = f[3]; z = f[2]; cy = f[1]; v = f[0];
    case (int'(c) / 2)
      0: r = z;
      1: r = cy;
      2: r = n;
      3: r = v;
      4: r = cy && !z;
      5: r = (n == v);
      6: r = !z && (n == v);
      default: r = 1'b1;
    endcase
    if ((int'(c) % 2 == 1) && c != 4'hF) r = !r;
    return r;
  endfunction

  function automatic bit ref_is_b(input logic [31:0] ins);
    return (ins >> 26) == 32'd5;
  endfunction

  function automatic bit ref_taken();
    logic [3:0] f;
    bit cbz, cbnz, bc;
    if (!m_valid || stall) return 1'b0;
    f = m_flags;
`ifdef BRANCH_FLAG_BYPASS_EN
    if (flag_we) f = flags_in;
`endif
    cbz  = (m_instr >> 24) == 32'hB4;
    cbnz = (m_instr >> 24) == 32'hB5;
    bc   = ((m_instr >> 24) == 32'h54) && ((m_instr & 32'h10) == 0);
    return ref_is_b(m_instr) || (cbz && rt_data == 0) || (cbnz && rt_data != 0) ||
           (bc && ref_cond(m_instr[3:0], f));
  endfunction

  // Advance one clock edge and move the reference model along with it.
  task automatic tick();
    bit t;
    t = ref_taken();
    @(posedge clk);
    if (rst) begin
      m_instr = NOP; m_pc = 0; m_valid = 0; m_flags = 0;
    end else begin
      if (flag_we) m_flags = flags_in;
      if (!stall) begin
        if (t) begin
          m_instr = NOP; m_pc = pc_in; m_valid = 0;
        end else begin
          m_instr = instr_in; m_pc = pc_in; m_valid = 1;
        end
      end
    end
    #1;
  endtask

  task automatic test_reset();
    rst = 1; instr_in = 32'h14000002; pc_in = 32'h8; stall = 0;
    flag_we = 1; flags_in = 4'hF; rt_data = 0;
    tick(); tick();
    @(negedge clk);
    checks++; if (valid_id !== 1'b0) begin errors++; $display("FAIL reset_valid got %0b want 0", valid_id); end
    checks++; if (instr_id !== NOP) begin errors++; $display("FAIL reset_instr got %h want %h", instr_id, NOP); end
    checks++; if (brTaken !== 1'b0) begin errors++; $display("FAIL reset_taken got %0b want 0", brTaken); end
    checks++; if (curAddress !== 32'h0) begin errors++; $display("FAIL reset_pc got %h want 0", curAddress); end
    checks++; if (rt_index !== 5'h1F) begin errors++; $display("FAIL reset_rt got %h want 1f", rt_index); end
    checks++; if (UncondBr !== 1'b0 || brAddr26 !== 26'h0 || condAddr19 !== 19'h0) begin
      errors++; $display("FAIL reset_fields got u=%0b b26=%h c19=%h want 0/0/0", UncondBr, brAddr26, condAddr19);
    end
    rst = 0; flag_we = 0; flags_in = 0;
  endtask

  task automatic test_uncond();
    instr_in = 32'h14000002; pc_in = 32'h10;
    tick();
    instr_in = ADD_I; pc_in = 32'h14;
    @(negedge clk);
    checks++; if (UncondBr !== 1'b1 || brTaken !== 1'b1) begin
      errors++; $display("FAIL b_taken got u=%0b t=%0b want 1/1", UncondBr, brTaken);
    end
    checks++; if (brAddr26 !== 26'h2) begin errors++; $display("FAIL b_addr26 got %h want 2", brAddr26); end
    checks++; if (curAddress !== 32'h10) begin errors++; $display("FAIL b_pc got %h want 10", curAddress); end
    tick();
    @(negedge clk);
    checks++; if (valid_id !== 1'b0 || brTaken !== 1'b0) begin
      errors++; $display("FAIL b_bubble got v=%0b t=%0b want 0/0", valid_id, brTaken);
    end
  endtask

  task automatic test_cbz();
    instr_in = 32'hB4000023; pc_in = 32'h20; rt_data = 0;
    tick();
    @(negedge clk);
    checks++; if (brTaken !== 1'b1 || UncondBr !== 1'b0) begin
      errors++; $display("FAIL cbz_taken got t=%0b u=%0b want 1/0", brTaken, UncondBr);
    end
    checks++; if (condAddr19 !== 19'h1 || rt_index !== 5'd3) begin
      errors++; $display("FAIL cbz_fields got c19=%h rt=%0d want 1/3", condAddr19, rt_index);
    end
    pc_in = 32'h24;
    tick();
    @(negedge clk);
    checks++; if (valid_id !== 1'b0) begin errors++; $display("FAIL cbz_squash got v=%0b want 0", valid_id); end
    tick();
    rt_data = 64'h5;
    @(negedge clk);
    checks++; if (brTaken !== 1'b0 || valid_id !== 1'b1) begin
      errors++; $display("FAIL cbz_nottaken got t=%0b v=%0b want 0/1", brTaken, valid_id);
    end
    instr_in = ADD_I; pc_in = 32'h28;
    tick();
    @(negedge clk);
    checks++; if (valid_id !== 1'b1 || instr_id !== ADD_I) begin
      errors++; $display("FAIL cbz_next got v=%0b i=%h want 1/%h", valid_id, instr_id, ADD_I);
    end
  endtask

  task automatic test_bcond();
    flag_we = 1; flags_in = 4'b0100; instr_in = ADD_I; pc_in = 32'h2C;
    tick();
    flag_we = 0; instr_in = 32'h54000040; pc_in = 32'h30;
    tick();
    instr_in = ADD_I; pc_in = 32'h34;
    @(negedge clk);
    checks++; if (brTaken !== 1'b1) begin errors++; $display("FAIL beq_z1 got %0b want 1", brTaken); end
    tick();
    flag_we = 1; flags_in = 4'b0000;
    tick();
    flag_we = 0; instr_in = 32'h54000040; pc_in = 32'h38;
    tick();
    @(negedge clk);
    checks++; if (brTaken !== 1'b0 || valid_id !== 1'b1) begin
      errors++; $display("FAIL beq_z0 got t=%0b v=%0b want 0/1", brTaken, valid_id);
    end
    flag_we = 1; flags_in = 4'b1001; instr_in = 32'h5400004A; pc_in = 32'h3C;
    tick();
    flag_we = 0;
    @(negedge clk);
    checks++; if (brTaken !== 1'b1) begin errors++; $display("FAIL bge_nv got %0b want 1", brTaken); end
  endtask

  task automatic test_stall();
    instr_in = 32'h14000002; pc_in = 32'h40;
    tick(); tick();
    stall = 1; instr_in = ADD_I; pc_in = 32'h44;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++; if (brTaken !== 1'b0 || instr_id !== 32'h14000002 || curAddress !== 32'h40 || valid_id !== 1'b1) begin
        errors++; $display("FAIL stall_hold[%0d] got t=%0b i=%h pc=%h v=%0b want 0/14000002/40/1",
                           i, brTaken, instr_id, curAddress, valid_id);
      end
      tick();
    end
    stall = 0;
    @(negedge clk);
    checks++; if (brTaken !== 1'b1) begin errors++; $display("FAIL stall_release got %0b want 1", brTaken); end
    tick();
    @(negedge clk);
    checks++; if (valid_id !== 1'b0 || curAddress !== 32'h44) begin
      errors++; $display("FAIL stall_bubble got v=%0b pc=%h want 0/44", valid_id, curAddress);
    end
  endtask

  task automatic test_bypass();
    bit exp;
`ifdef BRANCH_FLAG_BYPASS_EN
    exp = 1'b1;
`else
    exp = 1'b0;
`endif
    instr_in = 32'h54000040; pc_in = 32'h50;
    tick();
    flag_we = 1; flags_in = 4'b0100;
    @(negedge clk);
    checks++; if (brTaken !== exp) begin errors++; $display("FAIL bypass got %0b want %0b", brTaken, exp); end
    flag_we = 0; instr_in = ADD_I; pc_in = 32'h54;
    tick();
  endtask

  task automatic test_random();
    logic [31:0] ins;
    logic [31:0] pc;
    pc = 32'h100;
    for (int cyc = 0; cyc < 400; cyc++) begin
      case ($urandom_range(0, 5))
        0: ins = {6'b000101, 26'($urandom)};
        1: ins = {8'hB4, 24'($urandom)};
        2: ins = {8'hB5, 24'($urandom)};
        3: begin ins = {8'h54, 24'($urandom)}; ins[4] = 1'b0; end
        4: begin ins = {8'h54, 24'($urandom)}; ins[4] = 1'b1; end
        default: ins = $urandom;
      endcase
      pc       = pc + 4;
      instr_in = ins;
      pc_in    = pc;
      rst      = ($urandom_range(0, 49) == 0);
      stall    = ($urandom_range(0, 3) == 0);
      flag_we  = ($urandom_range(0, 2) == 0);
      flags_in = 4'($urandom);
      rt_data  = ($urandom_range(0, 1) == 0) ? '0 : {$urandom, $urandom};
      @(negedge clk);
      checks++; if (instr_id !== m_instr || valid_id !== m_valid || curAddress !== m_pc) begin
        errors++; $display("FAIL rnd_ifid[%0d] got i=%h v=%0b pc=%h want i=%h v=%0b pc=%h",
                           cyc, instr_id, valid_id, curAddress, m_instr, m_valid, m_pc);
      end
      checks++; if (brTaken !== ref_taken()) begin
        errors++; $display("FAIL rnd_taken[%0d] got %0b want %0b", cyc, brTaken, ref_taken());
      end
      checks++; if (UncondBr !== (m_valid && ref_is_b(m_instr))) begin
        errors++; $display("FAIL rnd_uncond[%0d] got %0b want %0b", cyc, UncondBr, m_valid && ref_is_b(m_instr));
      end
      checks++; if (rt_index !== m_instr[4:0] ||
                    brAddr26 !== (m_valid ? m_instr[25:0] : 26'h0) ||
                    condAddr19 !== (m_valid ? m_instr[23:5] : 19'h0)) begin
        errors++; $display("FAIL rnd_fields[%0d] got rt=%h b26=%h c19=%h for i=%h v=%0b",
                           cyc, rt_index, brAddr26, condAddr19, m_instr, m_valid);
      end
      tick();
    end
    rst = 0; stall = 0; flag_we = 0;
  endtask

  initial begin
    m_instr = NOP; m_pc = 0; m_valid = 0; m_flags = 0;
    test_reset();
    test_uncond();
    test_cbz();
    test_bcond();
    test_stall();
    test_bypass();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
